// File: rtl/tc_switch_pkg.sv
// rtl/tc_switch_pkg.sv - shared types and constants for the tc_switch tri-state bus switch
package tc_switch_pkg;

  typedef enum logic {
    COMB = 1'b0,
    REG  = 1'b1
  } drive_mode_e;

  // Single released bit; replicate to the bus width to float a whole net.
  localparam logic Z_FILL = 1'bz;

  function automatic drive_mode_e mode_from_param(input int registered);
    return (registered != 0) ? REG : COMB;
  endfunction

endpackage

// File: rtl/tc_switch_contention_mon.sv
// rtl/tc_switch_contention_mon.sv - compares the sensed bus against driven data, sticky contention flag
module tc_switch_contention_mon
  import tc_switch_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             check,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] bus_sense,
  input  logic             clear,
  output logic             contention
);

  logic mismatch;

  // Case inequality so X/Z on the sensed net counts as a disagreement.
  assign mismatch = check && (bus_sense !== expected);

  // A new mismatch outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention <= 1'b0;
    end else if (mismatch) begin
      contention <= 1'b1;
    end else if (clear) begin
      contention <= 1'b0;
    end
  end

endmodule

// File: rtl/tc_switch.sv
// rtl/tc_switch.sv - tri-state bus switch with optional output register
// Define TC_SWITCH_CONTENTION_CHECK_EN to build in the bus contention monitor.
module tc_switch
  import tc_switch_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int REGISTERED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output tri   [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] bus_sense,
  input  logic             clear_contention,
  output logic             driving,
  output logic             contention
);

  localparam drive_mode_e MODE = mode_from_param(REGISTERED);

  logic             eff_en;
  logic [WIDTH-1:0] eff_d;

  if (MODE == REG) begin : g_reg
    logic             en_q;
    logic [WIDTH-1:0] in_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q <= 1'b0;
        in_q <= '0;
      end else begin
        en_q <= en;
        in_q <= in;
      end
    end

    assign eff_en = en_q;
    assign eff_d  = in_q;
  end else begin : g_comb
    // Gating with rst_n releases the bus the instant reset asserts.
    assign eff_en = en & rst_n;
    assign eff_d  = in;

    logic unused_clk;
    assign unused_clk = clk;
  end

  assign out     = eff_en ? eff_d : {WIDTH{Z_FILL}};
  assign driving = eff_en;

`ifdef TC_SWITCH_CONTENTION_CHECK_EN
  tc_switch_contention_mon #(
    .WIDTH (WIDTH)
  ) u_contention_mon (
    .clk        (clk),
    .rst_n      (rst_n),
    .check      (eff_en),
    .expected   (eff_d),
    .bus_sense  (bus_sense),
    .clear      (clear_contention),
    .contention (contention)
  );
`else
  assign contention = 1'b0;

  logic unused_mon;
  assign unused_mon = ^{bus_sense, clear_contention};
`endif

endmodule

// File: tb/tb_tc_switch.sv
// tb/tb_tc_switch.sv - scoreboard bench: two combinational and two registered switches on two shared nets
module tb_tc_switch;

  localparam int W = 2;
`ifdef TC_SWITCH_CONTENTION_CHECK_EN
  localparam logic CC = 1'b1;
`else
  localparam logic CC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         clr   = 1'b0;
  logic         en_a0 = 1'b1, en_b0 = 1'b1, en_a1 = 1'b1, en_b1 = 1'b1;
  logic [W-1:0] in_a0 = '0, in_b0 = '0, in_a1 = '0, in_b1 = '0;
  tri   [W-1:0] bus0, bus1;
  logic         drv_a0, drv_b0, drv_a1, drv_b1;
  logic         cont_a0, cont_b0, cont_a1, cont_b1;

  tc_switch #(.WIDTH(W), .REGISTERED(0)) u_a0 (
    .clk(clk), .rst_n(rst_n), .en(en_a0), .in(in_a0), .out(bus0), .bus_sense(bus0),
    .clear_contention(clr), .driving(drv_a0), .contention(cont_a0));
  tc_switch #(.WIDTH(W), .REGISTERED(0)) u_b0 (
    .clk(clk), .rst_n(rst_n), .en(en_b0), .in(in_b0), .out(bus0), .bus_sense(bus0),
    .clear_contention(clr), .driving(drv_b0), .contention(cont_b0));
  tc_switch #(.WIDTH(W), .REGISTERED(1)) u_a1 (
    .clk(clk), .rst_n(rst_n), .en(en_a1), .in(in_a1), .out(bus1), .bus_sense(bus1),
    .clear_contention(clr), .driving(drv_a1), .contention(cont_a1));
  tc_switch #(.WIDTH(W), .REGISTERED(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .en(en_b1), .in(in_b1), .out(bus1), .bus_sense(bus1),
    .clear_contention(clr), .driving(drv_b1), .contention(cont_b1));

  // Bit order for drv/cont is {b1, a1, b0, a0}.
  typedef struct {
    string        name;
    logic [3:0]   drv;
    bit           c0;
    logic [W-1:0] v0;
    bit           c1;
    logic [W-1:0] v1;
    logic [3:0]   cont;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   applied     = 0;
  int   miscompares = 0;

  task automatic push(input string name, input logic [3:0] drv, input bit c0, input logic [W-1:0] v0,
                      input bit c1, input logic [W-1:0] v1, input logic [3:0] cont);
    exp_t e;
    e.name = name; e.drv = drv; e.c0 = c0; e.v0 = v0; e.c1 = c1; e.v1 = v1;
    e.cont = CC ? cont : 4'b0000;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        applied++;
        if ({drv_b1, drv_a1, drv_b0, drv_a0} !== mon_e.drv) begin
          miscompares++;
          $display("FAIL %s driving got %b want %b", mon_e.name, {drv_b1, drv_a1, drv_b0, drv_a0}, mon_e.drv);
        end
        applied++;
        if ({cont_b1, cont_a1, cont_b0, cont_a0} !== mon_e.cont) begin
          miscompares++;
          $display("FAIL %s contention got %b want %b", mon_e.name, {cont_b1, cont_a1, cont_b0, cont_a0}, mon_e.cont);
        end
        if (mon_e.c0) begin
          applied++;
          if (bus0 !== mon_e.v0) begin
            miscompares++;
            $display("FAIL %s bus0 got %b want %b", mon_e.name, bus0, mon_e.v0);
          end
        end
        if (mon_e.c1) begin
          applied++;
          if (bus1 !== mon_e.v1) begin
            miscompares++;
            $display("FAIL %s bus1 got %b want %b", mon_e.name, bus1, mon_e.v1);
          end
        end
      end
    end
  end

  initial begin
    step(); push("reset_all_en", 4'b0000, 0, '0, 0, '0, 4'b0000);
    step(); rst_n = 1'b1; {en_a0, en_b0, en_a1, en_b1} = 4'b0000;
            push("release", 4'b0000, 0, '0, 0, '0, 4'b0000);

    step(); in_a0 = 2'b11; in_b0 = 2'b00; en_a0 = 1'b1;
            push("a0_only_11", 4'b0001, 1, 2'b11, 0, '0, 4'b0000);
    step(); en_a0 = 1'b0; en_b0 = 1'b1;
            push("b0_only_00", 4'b0010, 1, 2'b00, 0, '0, 4'b0000);
    step(); en_b0 = 1'b0;
            push("none_0", 4'b0000, 0, '0, 0, '0, 4'b0000);
    step(); in_a0 = 2'b00; in_b0 = 2'b11; en_a0 = 1'b1;
            push("a0_only_00", 4'b0001, 1, 2'b00, 0, '0, 4'b0000);
    step(); en_a0 = 1'b0; en_b0 = 1'b1;
            push("b0_only_11", 4'b0010, 1, 2'b11, 0, '0, 4'b0000);
    step(); en_b0 = 1'b0;
            push("none_1", 4'b0000, 0, '0, 0, '0, 4'b0000);

    step(); in_a0 = 2'b01; in_b0 = 2'b10; en_a0 = 1'b1; en_b0 = 1'b1;
            push("contend", 4'b0011, 0, '0, 0, '0, 4'b0000);
    step(); en_a0 = 1'b0; en_b0 = 1'b0;
            push("contend_set", 4'b0000, 0, '0, 0, '0, 4'b0011);
    step(); push("sticky_hold", 4'b0000, 0, '0, 0, '0, 4'b0011);
    step(); clr = 1'b1;
            push("clear_req", 4'b0000, 0, '0, 0, '0, 4'b0011);
    step(); clr = 1'b0;
            push("cleared", 4'b0000, 0, '0, 0, '0, 4'b0000);
    step(); en_a0 = 1'b1; en_b0 = 1'b1; clr = 1'b1;
            push("set_with_clear", 4'b0011, 0, '0, 0, '0, 4'b0000);
    step(); en_a0 = 1'b0; en_b0 = 1'b0;
            push("set_wins", 4'b0000, 0, '0, 0, '0, 4'b0011);
    step(); clr = 1'b0;
            push("clear_again", 4'b0000, 0, '0, 0, '0, 4'b0000);

    step(); in_a1 = 2'b11; en_a1 = 1'b1; en_a0 = 1'b1; en_b0 = 1'b1;
            push("reg_en_rise", 4'b0011, 0, '0, 0, '0, 4'b0000);
    step(); en_a0 = 1'b0; en_b0 = 1'b0;
            push("reg_drive", 4'b0100, 0, '0, 1, 2'b11, 4'b0011);
    step(); in_a1 = 2'b00;
            push("reg_data_lag", 4'b0100, 0, '0, 1, 2'b11, 4'b0011);
    step(); push("reg_data_new", 4'b0100, 0, '0, 1, 2'b00, 4'b0011);
    step(); in_a0 = 2'b10; en_a0 = 1'b1; rst_n = 1'b0;
            push("reset_mid_drive", 4'b0000, 0, '0, 0, '0, 4'b0000);
    step(); rst_n = 1'b1;
            push("release_comb", 4'b0001, 1, 2'b10, 0, '0, 4'b0000);
    step(); push("reg_resume", 4'b0101, 1, 2'b10, 1, 2'b00, 4'b0000);
    step(); en_a0 = 1'b0; en_a1 = 1'b0;
            push("disable_all", 4'b0100, 0, '0, 1, 2'b00, 4'b0000);
    step(); push("reg_release", 4'b0000, 0, '0, 0, '0, 4'b0000);

    step();
    applied++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/tc_switch.md
Name: tc_switch

Overview:
- Tri-state bus switch: drives `in` onto the shared net `out` while enabled; releases `out` to high-Z otherwise.
- Several instances may share one `out` net (wired bus); at most one should be enabled at a time.
- Sits at the boundary between logic and a shared bus net.
- Adds an optional output register, a drive-status output and an optional bus-contention detector.

Parameters:
- WIDTH, 1, bit width of in/out/bus_sense.
- REGISTERED, 0:
  - 0: combinational enable/data path.
  - 1: en and in are registered before driving out.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  drive enable.
- in  input  WIDTH  data to place on the bus.
- out  output (tri)  WIDTH  shared bus net; driven or high-Z.
- bus_sense  input  WIDTH  resolved value of the shared bus net, for contention checking.
- clear_contention  input  1  synchronous clear of the sticky contention flag.
- driving  output  1  high while this instance drives out.
- contention  output  1  sticky contention flag.

Behaviour:
- Effective enable and data, by mode:
  - REGISTERED=0: eff_en = en & rst_n; eff_d = in. Purely combinational; no clock latency.
  - REGISTERED=1: en_q/in_q load en/in on every rising clk; eff_en = en_q, eff_d = in_q. One-cycle latency from en/in to out.
- Output drive:
  - out = eff_en ? eff_d : all-bits-Z.
  - driving = eff_en.
- Reset (rst_n=0), asserted asynchronously in both modes:
  - out goes to all-Z immediately; driving=0; contention=0.
  - REGISTERED=1: en_q=0, in_q=0.
  - Reset mid-drive releases the bus in the same instant, without waiting for a clock edge.
- After reset release:
  - REGISTERED=0: drive resumes combinationally.
  - REGISTERED=1: drive resumes from the first rising edge with en=1.
- Disabled instances place no drivers on out: a single enabled instance fully determines the net.
  - Example: in=1 with the other instance disabled resolves to 1; in=0 resolves to 0.
- All enables low: net floats (Z).
- Two instances enabled with differing data: net resolves to X per 4-state rules. The switch does not arbitrate.
- in with X/Z bits while enabled: those bits are propagated as-is.

Optional Feature:
- Macro: TC_SWITCH_CONTENTION_CHECK_EN.
- With the macro defined:
  - On each rising clk with driving=1, compare bus_sense against eff_d bitwise using 4-state inequality.
  - Any bit mismatch sets contention; a bit that is X or Z on bus_sense counts as a mismatch.
  - contention is sticky until clear_contention=1 at a rising edge.
  - A set condition in the same cycle as clear_contention wins, so contention stays 1.
  - No check is made while driving=0.
- Without the macro: contention tied 0; bus_sense and clear_contention are unused.

Decomposition:
- Package tc_switch_pkg holds:
  - localparam Z_FILL (all-Z constant generator helper);
  - typedef drive_mode_e {COMB=0, REG=1}, matching the REGISTERED encoding.
- No sub-module needed for the driver.
- Natural optional sub-module: tc_switch_contention_mon (compare + sticky flag), instantiated only under the macro.

Test Plan:
All scenarios use two instances (A, B) sharing one out net, with bus_sense tied to that net.
- Reset: rst_n=0 with en_A=1, en_B=1 -> out=Z, driving=0, contention=0 immediately, both modes.
- REGISTERED=0, in_A=1, in_B=0:
  - en_A=1, en_B=0 -> out=1.
  - en_A=0, en_B=1 -> out=0.
  - both disabled -> out=Z.
- REGISTERED=0, in_A=0, in_B=1, enable each alone in turn -> out=0, then 1; both 0 -> out=Z.
- Contention, in_A=0, in_B=1, en_A=en_B=1:
  - out=X.
  - Macro on: contention_A=contention_B=1 after the next rising edge; stays 1 after the enables drop.
  - clear_contention pulse -> 0.
- REGISTERED=1, en_A rises at a cycle boundary with in_A=1 -> out stays Z until the next rising edge, then 1.
  - rst_n low mid-drive -> Z asynchronously.
- Macro off: same contention stimulus -> contention stays 0 throughout.
